// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants for the bus master and anything on the same bus.
// Holds the transfer-type, size and response encodings plus the word alignment
// mask applied to command addresses before they reach HADDR.
package ahb_pkg;

    localparam logic [1:0]  HTRANS_IDLE     = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ   = 2'b10;
    localparam logic [2:0]  HSIZE_WORD      = 3'b010;
    localparam logic        HRESP_OKAY      = 1'b0;
    localparam logic        HRESP_ERROR     = 1'b1;
    localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-word bus master.
// Converts a valid/ready command stream into NONSEQ word transfers, overlapping
// the next address phase with the current data phase, and returns one response
// pulse per accepted command in acceptance order.
//
// Ports:
//   HCLK, HRESETn          bus clock, async active-low reset
//   HADDR/HTRANS/HWRITE    registered address-phase outputs
//   HSIZE                  constant word size
//   HWDATA                 registered data-phase write data
//   HRDATA/HREADY/HRESP    slave return path
//   cmd_*                  command handshake (cmd_ready is combinational)
//   rsp_*                  one-cycle response pulse, no backpressure
//   busy                   any address/data phase or cancelled response pending
module ahb_lite_master
    import ahb_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    logic [31:0] haddr_q, haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] wstage_q, wstage_d;
    logic        dp_valid_q, dp_valid_d;
    logic        dp_write_q, dp_write_d;
    logic        cancel_pend_q, cancel_pend_d;
    logic        cancel_write_q, cancel_write_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_write_q, rsp_write_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic ap_valid, accept, promote, complete, err_first;

    assign ap_valid  = (htrans_q == HTRANS_NONSEQ);
    assign cmd_ready = HREADY & ~cancel_pend_q;
    assign accept    = cmd_valid & cmd_ready;
    assign promote   = HREADY & ap_valid;
    assign complete  = HREADY & dp_valid_q;
    // First cycle of a two-cycle ERROR: the queued address phase must be
    // withdrawn before the slave's HREADY=1 cycle would accept it.
    assign err_first = ~HREADY & (HRESP == HRESP_ERROR) & dp_valid_q & ap_valid;

    always_comb begin
        haddr_d        = haddr_q;
        htrans_d       = htrans_q;
        hwrite_d       = hwrite_q;
        hwdata_d       = hwdata_q;
        wstage_d       = wstage_q;
        dp_valid_d     = dp_valid_q;
        dp_write_d     = dp_write_q;
        cancel_pend_d  = cancel_pend_q;
        cancel_write_d = cancel_write_q;
        rsp_valid_d    = 1'b0;
        rsp_write_d    = rsp_write_q;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_err_d      = rsp_err_q;

        // Address phase
        if (accept) begin
            haddr_d  = cmd_addr & ADDR_ALIGN_MASK;
            htrans_d = HTRANS_NONSEQ;
            hwrite_d = cmd_write;
            wstage_d = cmd_wdata;
        end else if (HREADY) begin
            htrans_d = HTRANS_IDLE;
        end else if (err_first) begin
            htrans_d       = HTRANS_IDLE;
            cancel_pend_d  = 1'b1;
            cancel_write_d = hwrite_q;
        end

        // Data phase: promotion wins over clearing on a shared edge
        if (promote) begin
            dp_valid_d = 1'b1;
            dp_write_d = hwrite_q;
            if (hwrite_q) hwdata_d = wstage_q;
        end else if (complete) begin
            dp_valid_d = 1'b0;
        end

        // Response slot; the cancelled-command response only goes out once the
        // errored transfer has drained, so the two can never share a cycle.
        if (complete) begin
            rsp_valid_d = 1'b1;
            rsp_write_d = dp_write_q;
            rsp_err_d   = HRESP;
            rsp_rdata_d = (!dp_write_q && HRESP == HRESP_OKAY) ? HRDATA : 32'h0;
        end else if (cancel_pend_q && !dp_valid_q) begin
            rsp_valid_d   = 1'b1;
            rsp_write_d   = cancel_write_q;
            rsp_err_d     = 1'b1;
            rsp_rdata_d   = 32'h0;
            cancel_pend_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            haddr_q        <= 32'h0;
            htrans_q       <= HTRANS_IDLE;
            hwrite_q       <= 1'b0;
            hwdata_q       <= 32'h0;
            wstage_q       <= 32'h0;
            dp_valid_q     <= 1'b0;
            dp_write_q     <= 1'b0;
            cancel_pend_q  <= 1'b0;
            cancel_write_q <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_write_q    <= 1'b0;
            rsp_rdata_q    <= 32'h0;
            rsp_err_q      <= 1'b0;
        end else begin
            haddr_q        <= haddr_d;
            htrans_q       <= htrans_d;
            hwrite_q       <= hwrite_d;
            hwdata_q       <= hwdata_d;
            wstage_q       <= wstage_d;
            dp_valid_q     <= dp_valid_d;
            dp_write_q     <= dp_write_d;
            cancel_pend_q  <= cancel_pend_d;
            cancel_write_q <= cancel_write_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_write_q    <= rsp_write_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_err_q      <= rsp_err_d;
        end
    end

    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = HSIZE_WORD;
    assign HWDATA    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = ap_valid | dp_valid_q | cancel_pend_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: directed scenario tasks plus a randomized run
// against a transaction-level model (expected-response queue + reference memory)
// and a behavioural wait-state slave.
module tb_ahb_lite_master;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b1;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA = 32'h0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        rsp_valid, rsp_write, rsp_err, busy;
    logic [31:0] rsp_rdata;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
    } exp_t;

    always #5 HCLK = ~HCLK;

    ahb_lite_master dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    // Everything is driven and sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        #1 HRESETn = 1'b0;
        #1;
        n_chk++; if ({HTRANS, HADDR, HWRITE, HWDATA} !== {2'b00, 32'h0, 1'b0, 32'h0}) begin n_fail++; $display("FAIL rst_bus: got %h/%h/%b/%h want 0", HTRANS, HADDR, HWRITE, HWDATA); end
        n_chk++; if ({rsp_valid, rsp_write, rsp_err, rsp_rdata, busy} !== 36'h0) begin n_fail++; $display("FAIL rst_rsp: got v%b w%b e%b d%h busy%b want all 0", rsp_valid, rsp_write, rsp_err, rsp_rdata, busy); end
        n_chk++; if (HSIZE !== 3'b010) begin n_fail++; $display("FAIL rst_hsize: got %b want 010", HSIZE); end
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
        @(negedge HCLK) HRESETn = 1'b1;
        tick();
        // Reset in the middle of a transfer
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h1234_5670; cmd_wdata = 32'hDEAD_BEEF;
        tick();
        cmd_valid = 1'b0;
        n_chk++; if (HTRANS !== 2'b10) begin n_fail++; $display("FAIL rst_pre_nonseq: got %b want 10", HTRANS); end
        #3 HRESETn = 1'b0;
        #1;
        n_chk++; if ({HTRANS, rsp_valid, busy, HADDR} !== {2'b00, 1'b0, 1'b0, 32'h0}) begin n_fail++; $display("FAIL rst_async: got htrans %b rsp %b busy %b haddr %h want 0", HTRANS, rsp_valid, busy, HADDR); end
        @(negedge HCLK) HRESETn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_no_rsp: cycle %0d got rsp %b busy %b want 0", i, rsp_valid, busy); end
        end
    endtask

    task automatic test_write();
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h5000_0000; cmd_wdata = 32'h0012_0034;
        #1;
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready: got %b want 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        n_chk++; if ({HTRANS, HWRITE, HADDR, busy} !== {2'b10, 1'b1, 32'h5000_0000, 1'b1}) begin n_fail++; $display("FAIL wr_addr_phase: got %b %b %h busy %b want 10 1 50000000 1", HTRANS, HWRITE, HADDR, busy); end
        tick();
        n_chk++; if ({HWDATA, HTRANS, rsp_valid} !== {32'h0012_0034, 2'b00, 1'b0}) begin n_fail++; $display("FAIL wr_data_phase: got %h %b rsp %b want 00120034 00 0", HWDATA, HTRANS, rsp_valid); end
        tick();
        n_chk++; if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin n_fail++; $display("FAIL wr_rsp: got v%b w%b e%b d%h want 1 1 0 0", rsp_valid, rsp_write, rsp_err, rsp_rdata); end
        tick();
        n_chk++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL wr_done: got rsp %b busy %b want 0 0", rsp_valid, busy); end
    endtask

    task automatic test_read_stall();
        logic [66:0] held;
        HREADY = 1'b1; HRESP = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h5000_0006; cmd_wdata = $urandom();
        tick();
        cmd_valid = 1'b0;
        n_chk++; if ({HTRANS, HWRITE, HADDR} !== {2'b10, 1'b0, 32'h5000_0004}) begin n_fail++; $display("FAIL rd_addr: got %b %b %h want 10 0 50000004", HTRANS, HWRITE, HADDR); end
        tick();
        HREADY = 1'b0;
        held = {HADDR, HTRANS, HWRITE, HWDATA};
        for (int i = 0; i < 2; i++) begin
            HRDATA = $urandom();
            tick();
            n_chk++; if ({HADDR, HTRANS, HWRITE, HWDATA, rsp_valid, busy} !== {held, 1'b0, 1'b1}) begin n_fail++; $display("FAIL rd_stall_hold: cycle %0d got %h %b %b %h rsp %b busy %b want held", i, HADDR, HTRANS, HWRITE, HWDATA, rsp_valid, busy); end
        end
        HREADY = 1'b1; HRDATA = 32'hCAFE_F00D;
        tick();
        n_chk++; if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL rd_rsp: got v%b w%b e%b d%h want 1 0 0 cafef00d", rsp_valid, rsp_write, rsp_err, rsp_rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a[4];
        logic [31:0] d[4];
        for (int i = 0; i < 4; i++) begin a[i] = $urandom(); d[i] = $urandom(); end
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom();
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a[c]; cmd_wdata = d[c]; end
            else cmd_valid = 1'b0;
            #1;
            if (c < 4) begin
                n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: cmd %0d got %b want 1", c, cmd_ready); end
            end
            tick();
            if (c < 4) begin
                n_chk++; if ({HTRANS, HADDR} !== {2'b10, a[c] & 32'hFFFF_FFFC}) begin n_fail++; $display("FAIL b2b_addr: cmd %0d got %b %h want 10 %h", c, HTRANS, HADDR, a[c] & 32'hFFFF_FFFC); end
            end else begin
                n_chk++; if (HTRANS !== 2'b00) begin n_fail++; $display("FAIL b2b_idle: cycle %0d got %b want 00", c, HTRANS); end
            end
            if (c >= 1 && c <= 4) begin
                n_chk++; if (HWDATA !== d[c-1]) begin n_fail++; $display("FAIL b2b_wdata: cmd %0d got %h want %h", c - 1, HWDATA, d[c-1]); end
            end
            n_chk++; if (rsp_valid !== (c >= 2 && c <= 5)) begin n_fail++; $display("FAIL b2b_rsp_valid: cycle %0d got %b want %b", c, rsp_valid, (c >= 2 && c <= 5)); end
            if (c >= 2 && c <= 5) begin
                n_chk++; if ({rsp_write, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin n_fail++; $display("FAIL b2b_rsp: cmd %0d got w%b e%b d%h want 1 0 0", c - 2, rsp_write, rsp_err, rsp_rdata); end
            end
        end
    endtask

    task automatic test_error();
        logic [31:0] wd, rd2;
        wd = $urandom(); rd2 = $urandom();
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h5000_0020; cmd_wdata = wd;
        tick();
        cmd_write = 1'b0; cmd_addr = 32'h5000_0024;
        #1;
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL err_rd_ready: got %b want 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0; HREADY = 1'b0; HRESP = 1'b1;
        n_chk++; if ({HTRANS, HADDR, HWDATA} !== {2'b10, 32'h5000_0024, wd}) begin n_fail++; $display("FAIL err_overlap: got %b %h %h want 10 50000024 %h", HTRANS, HADDR, HWDATA, wd); end
        tick();
        n_chk++; if ({HTRANS, busy, rsp_valid} !== {2'b00, 1'b1, 1'b0}) begin n_fail++; $display("FAIL err_cancel_idle: got %b busy %b rsp %b want 00 1 0", HTRANS, busy, rsp_valid); end
        HREADY = 1'b1; HRESP = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h5000_0028;
        #1;
        n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL err_ready_2nd: got %b want 0", cmd_ready); end
        tick();
        HRESP = 1'b0;
        n_chk++; if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 1'b1, 32'h0}) begin n_fail++; $display("FAIL err_wr_rsp: got v%b w%b e%b d%h want 1 1 1 0", rsp_valid, rsp_write, rsp_err, rsp_rdata); end
        n_chk++; if ({cmd_ready, HTRANS} !== {1'b0, 2'b00}) begin n_fail++; $display("FAIL err_ready_hold: got ready %b htrans %b want 0 00", cmd_ready, HTRANS); end
        tick();
        n_chk++; if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b1, 32'h0}) begin n_fail++; $display("FAIL err_cancel_rsp: got v%b w%b e%b d%h want 1 0 1 0", rsp_valid, rsp_write, rsp_err, rsp_rdata); end
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL err_ready_back: got %b want 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0; HRDATA = rd2;
        n_chk++; if ({HTRANS, HADDR, rsp_valid} !== {2'b10, 32'h5000_0028, 1'b0}) begin n_fail++; $display("FAIL err_recover_addr: got %b %h rsp %b want 10 50000028 0", HTRANS, HADDR, rsp_valid); end
        tick();
        tick();
        n_chk++; if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, rd2}) begin n_fail++; $display("FAIL err_recover_rsp: got v%b w%b e%b d%h want 1 0 0 %h", rsp_valid, rsp_write, rsp_err, rsp_rdata, rd2); end
        tick();
    endtask

    task automatic test_hready_low();
        logic [31:0] rd;
        rd = $urandom();
        HREADY = 1'b0; HRESP = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h6000_0013;
        #1;
        n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL hrl_ready: got %b want 0", cmd_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_chk++; if ({HTRANS, busy} !== {2'b00, 1'b0}) begin n_fail++; $display("FAIL hrl_not_taken: cycle %0d got %b busy %b want 00 0", i, HTRANS, busy); end
        end
        HREADY = 1'b1;
        #1;
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL hrl_ready_back: got %b want 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0; HRDATA = rd;
        n_chk++; if ({HTRANS, HWRITE, HADDR} !== {2'b10, 1'b0, 32'h6000_0010}) begin n_fail++; $display("FAIL hrl_addr: got %b %b %h want 10 0 60000010", HTRANS, HWRITE, HADDR); end
        tick();
        tick();
        n_chk++; if ({rsp_valid, rsp_write, rsp_rdata} !== {1'b1, 1'b0, rd}) begin n_fail++; $display("FAIL hrl_rsp: got v%b w%b d%h want 1 0 %h", rsp_valid, rsp_write, rsp_rdata, rd); end
        tick();
    endtask

    // Random commands against a wait-state slave. The model is a reference
    // memory updated in acceptance order and a FIFO of expected responses.
    task automatic test_random();
        localparam int N = 80;
        exp_t        exp_q[$];
        exp_t        e;
        logic [31:0] smem[8];
        logic [31:0] rmem[8];
        logic        dp_act, dp_wr, rdy, acc;
        logic [2:0]  dp_idx, idx;
        int          issued, cyc;
        for (int i = 0; i < 8; i++) begin smem[i] = 32'hA500_0000 + i; rmem[i] = 32'hA500_0000 + i; end
        dp_act = 1'b0; dp_wr = 1'b0; dp_idx = 3'd0; acc = 1'b0; issued = 0; cyc = 0;
        cmd_valid = 1'b0; HRESP = 1'b0;
        while ((issued < N || exp_q.size() != 0) && cyc < 3000) begin
            if (rsp_valid) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_extra_rsp: got response w%b d%h want none", rsp_write, rsp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_write, rsp_err, rsp_rdata} !== {e.wr, 1'b0, e.rdata}) begin n_fail++; $display("FAIL rnd_rsp: got w%b e%b d%h want w%b e0 d%h", rsp_write, rsp_err, rsp_rdata, e.wr, e.rdata); end
                end
            end
            if (HTRANS == 2'b10) begin
                n_chk++; if ({HADDR[1:0], HSIZE} !== {2'b00, 3'b010}) begin n_fail++; $display("FAIL rnd_align: got addr %h size %b want aligned 010", HADDR, HSIZE); end
            end
            // slave
            rdy = ($urandom_range(0, 2) != 0);
            if (dp_act && rdy && dp_wr) smem[dp_idx] = HWDATA;
            HRDATA = (dp_act && !dp_wr) ? smem[dp_idx] : $urandom();
            if (rdy) begin dp_act = (HTRANS == 2'b10); dp_idx = HADDR[4:2]; dp_wr = HWRITE; end
            HREADY = rdy;
            // command driver
            if (acc) cmd_valid = 1'b0;
            if (!cmd_valid && issued < N && $urandom_range(0, 3) != 0) begin
                cmd_valid = 1'b1;
                cmd_write = $urandom_range(0, 1) == 1;
                cmd_addr  = 32'h5000_0000 | 32'($urandom_range(0, 31));
                cmd_wdata = $urandom();
            end
            #1;
            acc = cmd_valid && cmd_ready;
            if (acc) begin
                idx  = cmd_addr[4:2];
                e.wr = cmd_write;
                if (cmd_write) begin rmem[idx] = cmd_wdata; e.rdata = 32'h0; end
                else e.rdata = rmem[idx];
                exp_q.push_back(e);
                issued++;
            end
            tick();
            cyc++;
        end
        cmd_valid = 1'b0; HREADY = 1'b1;
        n_chk++; if (issued != N || exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_timeout: issued %0d pending %0d want %0d issued 0 pending", issued, exp_q.size(), N); end
        for (int i = 0; i < 8; i++) begin
            n_chk++; if (smem[i] !== rmem[i]) begin n_fail++; $display("FAIL rnd_mem: word %0d got %h want %h", i, smem[i], rmem[i]); end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_stall();
        test_back_to_back();
        test_error();
        test_hready_low();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- Single-outstanding-pipeline AHB-Lite bus master. It turns a simple command/response handshake into AHB-Lite single-word NONSEQ transfers, so local logic (test sequencer, DMA, sprite mover) can write position/control words to peripherals such as the VGA slave.
- It is the initiator end of the same bus the peripheral slaves respond on.
- It overlaps the next address phase with the current data phase.

Parameters:
- HSIZE_WORD, 3'b010, HSIZE driven on every transfer (32-bit only).
- ADDR_ALIGN_MASK, 32'hFFFF_FFFC, AND-mask applied to cmd_addr before it drives HADDR.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  asynchronous active-low reset.
- HADDR  out  32  address-phase address (registered).
- HTRANS  out  2  2'b00 IDLE or 2'b10 NONSEQ only (registered).
- HWRITE  out  1  address-phase write flag (registered).
- HSIZE  out  3  always HSIZE_WORD.
- HWDATA  out  32  data-phase write data (registered).
- HRDATA  in  32  read data from the slave mux.
- HREADY  in  1  transfer-complete / address-accepted.
- HRESP  in  1  0 OKAY, 1 ERROR.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid & cmd_ready.
- cmd_write  in  1  1 write, 0 read.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_write  out  1  direction of the responding command.
- rsp_rdata  out  32  read data; 0 for writes and for errors.
- rsp_err  out  1  ERROR response, or command cancelled by a preceding error.
- busy  out  1  address or data phase outstanding.

Behaviour:
- Reset (async, HRESETn low): HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_err=0, and all internal phase flags are cleared.
- Reset mid-transfer abandons the transfer; no response is issued for it.
- cmd_ready = HREADY & ~cancel_pend (combinational).
- Accept edge (cmd_valid & cmd_ready):
  - HADDR <= cmd_addr & ADDR_ALIGN_MASK, HTRANS <= NONSEQ, HWRITE <= cmd_write.
  - The write data is held in a staging register.
- Edge with HREADY=1 and no command accepted: HTRANS <= IDLE.
- Address-phase promotion: on an edge with HREADY=1 while HTRANS=NONSEQ:
  - The address phase becomes the data phase: dp_valid <= 1, dp_write <= HWRITE.
  - HWDATA <= staged wdata when writing; otherwise HWDATA holds its value.
- Data-phase completion: on an edge with HREADY=1 and dp_valid:
  - rsp_valid <= 1, rsp_write <= dp_write, rsp_err <= HRESP.
  - rsp_rdata <= HRDATA if read & ~HRESP, else 0.
  - dp_valid is cleared unless a new phase is promoted on the same edge.
- Latency, zero-wait slave: cmd accepted at edge N; address phase cycle N+1; data phase cycle N+2; rsp_valid high cycle N+3.
- Throughput: one command per cycle sustained when HREADY stays 1.
- Wait states (HREADY=0): HADDR/HTRANS/HWRITE/HWDATA are held. Exception: ERROR handling below.
- ERROR two-cycle response:
  - Edge with HREADY=0 & HRESP=1 & dp_valid: if HTRANS=NONSEQ, drive HTRANS <= IDLE and set cancel_pend, saving the cancelled command's direction.
  - The following HREADY=1 edge completes the errored transfer (rsp_err=1).
  - The next edge emits a second response for the cancelled command: rsp_valid=1, rsp_err=1, rsp_rdata=0. cancel_pend then clears.
  - While cancel_pend is set, cmd_ready=0, so response slots never collide.
- HRESP=1 with HREADY=1 on the first cycle is a slave protocol violation; it is treated as a normal errored completion.
- busy = (HTRANS==NONSEQ) | dp_valid | cancel_pend.
- Response ordering equals command acceptance order.

Decomposition:
- Shared package ahb_pkg: HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10, HSIZE_WORD=3'b010, HRESP_OKAY=1'b0, HRESP_ERROR=1'b1.
- No sub-module: a single flat block with address-phase, data-phase and response registers.

Test Plan:
- Reset with HRESETn asserted asynchronously mid-cycle -> HTRANS=IDLE and rsp_valid=0 immediately; no response issued afterwards.
- Zero-wait write cmd addr=32'h5000_0000, wdata=32'h0012_0034 -> HTRANS=NONSEQ, HWRITE=1 at N+1; HWDATA=32'h0012_0034 at N+2; rsp_valid, rsp_write=1, rsp_err=0 at N+3.
- Read addr=32'h5000_0006, slave stalls 2 cycles then HRDATA=32'hCAFE_F00D -> HADDR=32'h5000_0004; address outputs stable through the stall; rsp_rdata=32'hCAFE_F00D.
- Back-to-back 4 writes with HREADY=1 -> cmd_ready held 1; four consecutive NONSEQ cycles; four consecutive rsp_valid pulses in order.
- Write followed by read, slave gives ERROR on the write (HREADY=0/HRESP=1, then HREADY=1/HRESP=1) -> HTRANS goes IDLE in the second error cycle; rsp_err=1 for the write, then next cycle rsp_err=1, rsp_write=0 for the cancelled read; cmd_ready=0 until then.
- cmd_valid=1 while HREADY=0 -> cmd_ready=0; command not accepted until HREADY returns to 1.
